// File: rtl/display_scan_if.sv
// Port bundle between the display scan controller and whatever drives it.
// load is a one-cycle strobe with no ready: the controller always accepts it.
interface display_scan_if;
  logic        en;
  logic        load;
  logic [31:0] data_in;
  logic [7:0]  blank_in;
  logic [2:0]  num;
  logic [31:0] dig;
  logic [7:0]  an;
  logic        frame;

  modport master (
    output en, load, data_in, blank_in,
    input  num, dig, an, frame
  );

  modport slave (
    input  en, load, data_in, blank_in,
    output num, dig, an, frame
  );
endinterface

// File: rtl/display_scan.sv
// Eight-digit seven-segment scan controller: digit-rate prescaler, active-low
// anode drive with a guard gap, and a display word swapped only at frame wrap.
module display_scan #(
  parameter int DIV   = 100000,
  parameter int GUARD = 16
) (
  input logic          clk,
  input logic          rst,
  display_scan_if.slave bus
);
  localparam int PW = (DIV <= 2) ? 1 : $clog2(DIV);
  localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

  logic [PW-1:0] psc;
  logic [GW-1:0] guard;
  logic          en_q;
  logic [31:0]   pend_word;
  logic [7:0]    pend_mask;
  logic          pend_valid;
  logic [7:0]    mask;
  logic          tick;
  logic          boundary;

  assign tick     = bus.en && (psc == PW'(DIV - 1));
  assign boundary = tick && (bus.num == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      psc        <= '0;
      guard      <= '0;
      en_q       <= 1'b0;
      pend_word  <= '0;
      pend_mask  <= '0;
      pend_valid <= 1'b0;
      mask       <= '0;
      bus.num    <= '0;
      bus.dig    <= '0;
      bus.frame  <= 1'b0;
    end else begin
      en_q      <= bus.en;
      bus.frame <= boundary;

      if (tick) begin
        psc     <= '0;
        bus.num <= bus.num + 3'd1;
        guard   <= GW'(GUARD);
      end else begin
        if (bus.en)
          psc <= psc + PW'(1);
        if (guard != '0)
          guard <= guard - GW'(1);
      end

      if (bus.load) begin
        pend_word <= bus.data_in;
        pend_mask <= bus.blank_in;
      end

      // A load on the boundary itself bypasses the pending slot entirely.
      if (boundary) begin
        if (bus.load) begin
          bus.dig <= bus.data_in;
          mask    <= bus.blank_in;
        end else if (pend_valid) begin
          bus.dig <= pend_word;
          mask    <= pend_mask;
        end
        pend_valid <= 1'b0;
      end else if (bus.load) begin
        pend_valid <= 1'b1;
      end
    end
  end

  // Registered terms only, so en reaches the anodes one edge late by design.
  always_comb begin
    bus.an = 8'hFF;
    if (en_q && (guard == '0) && !mask[bus.num])
      bus.an = ~(8'b1 << bus.num);
  end
endmodule

// File: tb/tb_display_scan.sv
// Bench for display_scan with DIV=4, GUARD=1: vector table, directed corner
// sequences and random traffic against a cycle-count reference model.
module tb_display_scan;
  localparam int DIV   = 4;
  localparam int GUARD = 1;

  logic clk = 1'b0;
  logic rst;
  display_scan_if bus ();

  display_scan #(.DIV(DIV), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: enabled-cycle count, cycles since last tick, pending queue.
  int          m_ecount;
  int          m_since;
  logic        m_en_prev;
  logic [31:0] m_dig;
  logic [7:0]  m_mask;
  logic        m_frame;
  logic [39:0] pend_q[$];

  function automatic int m_num();
    return (m_ecount / DIV) % 8;
  endfunction

  function automatic logic [7:0] m_an();
    int n;
    n = m_num();
    if (!m_en_prev || (m_since < GUARD) || m_mask[n])
      return 8'hFF;
    return 8'hFF - 8'((1 << n));
  endfunction

  function automatic logic next_is_boundary();
    return bus.en && (m_ecount % DIV == DIV - 1) && (m_num() == 7);
  endfunction

  task automatic model_reset();
    m_ecount  = 0;
    m_since   = GUARD;
    m_en_prev = 1'b0;
    m_dig     = '0;
    m_mask    = '0;
    m_frame   = 1'b0;
    pend_q.delete();
  endtask

  task automatic model_edge();
    logic tick, bnd;
    if (rst) begin
      model_reset();
      return;
    end
    tick    = bus.en && (m_ecount % DIV == DIV - 1);
    bnd     = tick && (m_num() == 7);
    m_frame = bnd;
    if (bnd) begin
      if (bus.load) begin
        m_dig  = bus.data_in;
        m_mask = bus.blank_in;
      end else if (pend_q.size() > 0) begin
        m_dig  = pend_q[$][39:8];
        m_mask = pend_q[$][7:0];
      end
      pend_q.delete();
    end else if (bus.load) begin
      pend_q.push_back({bus.data_in, bus.blank_in});
    end
    if (tick) m_since = 0;
    else if (m_since < 1000) m_since++;
    if (bus.en) m_ecount = (m_ecount + 1) % (8 * DIV);
    m_en_prev = bus.en;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: model follows the edge, outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_num",   32'(bus.num),   32'(m_num()));
    chk("model_dig",   bus.dig,        m_dig);
    chk("model_an",    32'(bus.an),    32'(m_an()));
    chk("model_frame", 32'(bus.frame), 32'(m_frame));
  endtask

  task automatic pulse_load(input logic [31:0] d, input logic [7:0] b);
    bus.load = 1'b1; bus.data_in = d; bus.blank_in = b;
    step();
    bus.load = 1'b0;
  endtask

  task automatic run_to_frame(input int limit, output int cycles);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (!bus.frame && cycles < limit);
    chk("frame_timeout", 32'(bus.frame), 32'd1);
  endtask

  task automatic wait_num(input int n, input int ph, input int limit);
    int k;
    k = 0;
    while (!(m_num() == n && m_ecount % DIV == ph) && k < limit) begin
      step();
      k++;
    end
    chk("wait_num_timeout", 32'(m_num() == n && m_ecount % DIV == ph), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] num;
    logic [7:0] an;
    logic       frame;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int cyc, lit;
    tbl[0] = '{1'b1, 1'b0, 3'd0, 8'hFF, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 3'd0, 8'hFF, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 3'd0, 8'hFE, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 3'd0, 8'hFE, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 3'd0, 8'hFE, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 3'd1, 8'hFF, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 3'd1, 8'hFD, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 3'd1, 8'hFD, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 3'd1, 8'hFD, 1'b0};
    tbl[9] = '{1'b0, 1'b1, 3'd2, 8'hFF, 1'b0};

    rst = 1'b1; bus.en = 1'b0; bus.load = 1'b0; bus.data_in = '0; bus.blank_in = '0;
    model_reset();

    // Reset and first slots
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; bus.en = tbl[i].en;
      step();
      chk("tbl_num",   32'(bus.num),   32'(tbl[i].num));
      chk("tbl_an",    32'(bus.an),    32'(tbl[i].an));
      chk("tbl_frame", 32'(bus.frame), 32'(tbl[i].frame));
      chk("tbl_dig",   bus.dig,        32'h0);
    end
    run_to_frame(40, cyc);
    chk("frame_num0", 32'(bus.num), 32'd0);
    run_to_frame(40, cyc);
    chk("frame_period", 32'(cyc), 32'(8 * DIV));

    // Deferred load at num 3
    wait_num(3, 1, 40);
    pulse_load(32'h12345678, 8'h00);
    while (!bus.frame && m_num() != 0) begin
      chk("deferred_hold", bus.dig, 32'h0);
      step();
    end
    if (!bus.frame) run_to_frame(40, cyc);
    chk("deferred_dig", bus.dig, 32'h12345678);
    chk("deferred_code7", 32'(bus.dig[31:28]), 32'd1);

    // Double load: last one wins
    wait_num(1, 2, 40);
    pulse_load(32'hAAAAAAAA, 8'h00);
    step();
    pulse_load(32'h55555555, 8'h00);
    run_to_frame(40, cyc);
    chk("double_dig", bus.dig, 32'h55555555);

    // Coincident load after an earlier pending load
    wait_num(2, 0, 40);
    pulse_load(32'h11111111, 8'h00);
    cyc = 0;
    while (!next_is_boundary() && cyc < 40) begin step(); cyc++; end
    pulse_load(32'hCAFEF00D, 8'h00);
    chk("coinc_frame", 32'(bus.frame), 32'd1);
    chk("coinc_dig", bus.dig, 32'hCAFEF00D);
    run_to_frame(40, cyc);
    chk("coinc_no_second", bus.dig, 32'hCAFEF00D);

    // Blanking digits 0 and 7
    wait_num(4, 1, 40);
    pulse_load(32'h87654321, 8'b1000_0001);
    run_to_frame(40, cyc);
    chk("blank_dig", bus.dig, 32'h87654321);
    lit = 0;
    for (int k = 0; k < 8 * DIV; k++) begin
      if (m_num() == 0 || m_num() == 7) chk("blank_dark", 32'(bus.an), 32'hFF);
      else if (bus.an != 8'hFF) lit++;
      step();
    end
    chk("blank_lit_count", 32'(lit), 32'(6 * (DIV - GUARD)));
    wait_num(5, 1, 40);
    pulse_load(32'h0, 8'h00);
    run_to_frame(40, cyc);

    // Enable freeze at num 2, prescaler 1
    wait_num(2, 1, 40);
    bus.en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("freeze_num", 32'(bus.num), 32'd2);
      chk("freeze_an",  32'(bus.an),  32'hFF);
    end
    bus.en = 1'b1;
    step(); step();
    chk("resume_num_hold", 32'(bus.num), 32'd2);
    step();
    chk("resume_num_adv", 32'(bus.num), 32'd3);

    // Mid-frame reset discards pending word
    wait_num(5, 1, 40);
    pulse_load(32'hDEADBEEF, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_num", 32'(bus.num), 32'd0);
    chk("rst_dig", bus.dig, 32'h0);
    chk("rst_an",  32'(bus.an), 32'hFF);
    run_to_frame(40, cyc);
    chk("rst_dig_after_frame", bus.dig, 32'h0);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      rst          = ($urandom_range(0, 399) == 0);
      bus.en       = ($urandom_range(0, 9) != 0);
      bus.load     = ($urandom_range(0, 11) == 0);
      bus.data_in  = $urandom;
      bus.blank_in = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step();
    end
    rst = 1'b0; bus.load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/display_scan.md
# display_scan

Time-multiplexing scan controller for the 8-digit seven-segment display. It divides the system clock down to a digit rate, steps a 3-bit digit index `num` through 0..7 and drives the matching active-low anode. It also holds the 32-bit display word `dig` and swaps in a newly loaded word only at a frame boundary, so a frame never shows a mix of old and new digits. Its outputs `num` and `dig` feed the nibble selector `display_sel`, whose 4-bit `code` then goes to the segment decoder.

## Interface
- `DIV`, 100000: clock cycles per digit slot; must be ≥ 2.
- `GUARD`, 16: cycles at the start of each slot during which all anodes are off (anti-ghosting); must be < `DIV`; 0 disables the guard.
- `clk` in 1: system clock. The block uses this single clock only.
- `rst` in 1: synchronous reset, active-high.
- `en` in 1: scan enable. When low, scanning freezes and the display is dark.
- `load` in 1: single-cycle strobe that captures `data_in` and `blank_in`.
- `data_in` in 32: new display word; nibble k is digit k.
- `blank_in` in 8: per-digit blank mask; bit k = 1 keeps digit k dark.
- `num` out 3: current digit index, to `display_sel.num`.
- `dig` out 32: displayed word, to `display_sel.dig`.
- `an` out 8: anode enables, active low; bit k drives digit k.
- `frame` out 1: one-cycle pulse when `num` wraps from 7 to 0.

## Operation
- Reset values:
  - `num` = 0, `dig` = 0, `frame` = 0, `an` = 8'hFF.
  - Internal registers: prescaler = 0, guard counter = 0, pending word and pending mask = 0, pending-valid = 0, active blank mask = 0.
- Prescaler counts 0..DIV-1 while `en` = 1 and holds its value while `en` = 0.
  - tick = `en` && prescaler == DIV-1. On a tick the prescaler returns to 0.
- On a tick:
  - `num` <= `num` + 1 modulo 8, so 7 wraps to 0.
  - Guard counter <= GUARD.
  - Otherwise the guard counter decrements while nonzero.
- Frame boundary = a tick with `num` == 7. On that cycle:
  - `frame` <= 1 for one cycle.
  - If pending-valid: `dig` <= pending word, active mask <= pending mask, pending-valid <= 0.
- `load` (takes effect at any time):
  - Pending word <= `data_in`, pending mask <= `blank_in`, pending-valid <= 1.
  - A later `load` before the boundary overwrites the pending values; the last one wins.
- `load` on the same cycle as a frame boundary: `data_in` and `blank_in` go straight to `dig` and the active mask, and pending-valid ends at 0.
- `an` is decoded from registers only, with no combinational path from inputs:
  - 8'hFF if `en` = 0, or guard counter ≠ 0, or active mask bit [`num`] = 1.
  - Otherwise ~(8'b1 << `num`).
- `rst` asserted mid-frame returns everything to reset values on the next edge and discards any pending word. `rst` has priority over `load` and `en`.

## Timing
- Digit slot = DIV cycles. Full frame = 8·DIV cycles.
- `num` changes on the clock edge that ends prescaler value DIV-1. `an` follows on the same edge; no extra latency.
- With GUARD = G > 0, `an` = 8'hFF for G cycles starting at the tick edge. The digit is lit for the remaining DIV-G cycles of the slot.
- `load` → visible on `dig`: at the next frame boundary edge, at most 8·DIV cycles later. If `load` coincides with the boundary, the new word is visible on that same edge.
- `frame` is high in the cycle right after the boundary edge, aligned with `num` = 0.
- `en` falling: `an` = 8'hFF on the next edge; `num` and the prescaler hold. `en` rising: scanning resumes from the held prescaler value.

## Test plan
Benches run with DIV = 4 and GUARD = 1.
1. **Reset and scan:**
   - Stimulus: `rst` for 2 cycles, then `en` = 1.
   - Required: `an` = FF and `num` = 0 during reset. `num` steps 0,1,…,7,0 every 4 cycles. `an` shows FF for 1 cycle and then ~(1<<num) for 3 cycles in each slot. `frame` pulses every 32 cycles, aligned with `num` = 0.
2. **Deferred load:**
   - Stimulus: `load` with `data_in` = 32'h12345678 while `num` = 3.
   - Required: `dig` stays 0 until the 7→0 boundary, then becomes 12345678. The word with `num` = 7 reaches `display_sel`, giving `code` = 1.
3. **Double load and coincident load:**
   - Loads of 32'hAAAA_AAAA then 32'h5555_5555 in the same frame: only 55555555 appears at the boundary.
   - `load` of 32'hCAFEF00D on the boundary cycle: `dig` = CAFEF00D on that same edge, and no second update happens at the following boundary.
4. **Blanking:**
   - Stimulus: `blank_in` = 8'b1000_0001 with a load.
   - Required: after the boundary, `an` stays FF for the entire slots with `num` = 0 and `num` = 7. The other digits light normally.
5. **Enable freeze:**
   - Stimulus: drop `en` for 10 cycles at `num` = 2, prescaler = 1.
   - Required: `an` = FF and `num` = 2 throughout. After `en` returns, `num` advances to 3 after 3 more enabled cycles (prescaler 1→2→3, then tick).
6. **Mid-operation reset:**
   - Stimulus: pending word 32'hDEADBEEF, `rst` pulse while `num` = 5.
   - Required: `num` = 0, `dig` = 0, `an` = FF, and `dig` is still 0 after the next frame boundary.
